seq_acesso_regs: RTL and testbench
==================================

// Module: seq_acesso_regs
// PURPOSE
//  Initiator side of the 8x8 register-bank interface (addR1/addR2/addWr/wrEn/dadoR*/dadoWr).
//  Accepts one register-to-register instruction via valid/ready and sequences bank reads.
//  Executes it on an internal 8-bit ALU and issues the bank write-back.
//  Sits between the instruction decoder and the register bank in the Nano datapath.
// PARAMETERS
//  DATA_W  8  bank word width; all arithmetic is modulo 2^DATA_W
//  ADDR_W  3  bank address width (2^ADDR_W registers)
// PORTS
//  clk          in   1       single system clock, rising edge
//  rst          in   1       asynchronous reset, active-low (rst==0 resets)
//  instr_valid  in   1       instruction fields valid
//  instr_ready  out  1       block can accept; high only in IDLE, forced 0 while rst==0
//  instr_op     in   3       0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 MOV,6 LDI,7 CMP
//  instr_rd     in   ADDR_W  destination register
//  instr_rs1    in   ADDR_W  source A
//  instr_rs2    in   ADDR_W  source B
//  instr_imm    in   DATA_W  immediate (LDI only)
//  addR1        out  ADDR_W  bank read address A
//  addR2        out  ADDR_W  bank read address B
//  dadoR1       in   DATA_W  bank read data A (registered in bank, 1-cycle latency)
//  dadoR2       in   DATA_W  bank read data B
//  addWr        out  ADDR_W  bank write address
//  dadoWr       out  DATA_W  bank write data
//  wrEn         out  1       bank write enable, high for exactly one cycle per write
//  done         out  1       one-cycle pulse: instruction retired, flags updated
//  flag_z       out  1       result==0 of last retired instruction
//  flag_c       out  1       ADD carry-out / SUB,CMP borrow (rs1<rs2 unsigned); 0 for others
// BEHAVIOUR
//  States: IDLE, READ, EXEC, WB. All outputs registered except instr_ready (=state==IDLE && rst).
//  Reset (rst==0, async): state IDLE; addR1/addR2/addWr/dadoWr/wrEn/done/flag_z/flag_c = 0.
//  Acceptance: at rising edge with IDLE && instr_valid; op/rd/rs1/rs2/imm latched internally.
//  IDLE --accept, op!=LDI--> READ: addR1=rs1, addR2=rs2 driven this cycle; bank samples at edge.
//  READ --> EXEC: dadoR1/dadoR2 valid this cycle; ALU result captured at end of EXEC.
//  EXEC --> WB (op!=CMP): wrEn=1, addWr=rd, dadoWr=result for this one cycle.
//  EXEC --> IDLE (CMP): no wrEn; done=1 and flags updated next cycle.
//  IDLE --accept LDI--> WB directly with dadoWr=imm; flag_z=(imm==0), flag_c=0.
//  WB --> IDLE: done=1 for one cycle; flag_z/flag_c take the result's values at the same edge.
//  Latency: ALU ops accept->done = 4 edges; LDI = 2; CMP = 3. Throughput: 1 instr / 4 cycles.
//  Earliest next accept is the cycle done is high (state already IDLE).
//  ALU: ADD {c,r}=A+B (9-bit); SUB/CMP r=A-B, c=(A<B); AND/OR/XOR bitwise, c=0; MOV r=A, c=0.
//  Overflow wraps modulo 256; no signed overflow flag.
//  Flags hold between instructions; change only on the done edge.
//  wrEn never asserted outside WB; addWr/dadoWr hold last values when wrEn=0.
//  rd==rs1/rs2 is legal: operands read before write; a following instruction reads the new value.
//  Reset mid-operation: any state -> IDLE immediately; wrEn deasserts asynchronously.
//  No pending write is issued after reset release; the in-flight instruction is discarded, no done.
//  instr_valid while not ready: ignored; fields need not be held (no accept until IDLE).
// TESTING  (bank reset contents r[i]=i)
//  ADD rd=1,rs1=2,rs2=3 -> addR1=2,addR2=3 in READ; wrEn,addWr=1,dadoWr=0x05 in WB; done; z=0,c=0.
//  SUB rd=0,rs1=2,rs2=3 -> dadoWr=0xFF, c=1, z=0; done exactly 4 edges after accept.
//  LDI rd=4,imm=0xFF then ADD rd=5,rs1=4,rs2=1 -> r4=0xFF; r5=0x00, z=1, c=1.
//  CMP rs1=6,rs2=6 -> wrEn stays 0 throughout; done after 3 edges; z=1, c=0; r6 still 0x06.
//  Reset mid-op: drop rst in EXEC of ADD rd=7 -> wrEn=0, no done, r7 unchanged=0x07, ready after release.
//  instr_valid held high with 3 ADDs -> accepts 4 cycles apart, one done pulse each, no wrEn overlap.

Source files
------------

// File: rtl/seq_acesso_regs_if.sv
// Register-bank access bundle: instruction handshake from the decoder plus the
// 8x8 bank read/write port.
//
// Handshake: an instruction transfers on a rising clk edge where instr_valid
// and instr_ready are both high; instr_ready depends only on the sequencer state
// (never on instr_valid), and the instruction fields only need to be stable in
// that transfer cycle.
interface seq_acesso_regs_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    // instruction handshake
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_op;
    logic [ADDR_W-1:0] instr_rd;
    logic [ADDR_W-1:0] instr_rs1;
    logic [ADDR_W-1:0] instr_rs2;
    logic [DATA_W-1:0] instr_imm;

    // register bank port
    logic [ADDR_W-1:0] addR1;
    logic [ADDR_W-1:0] addR2;
    logic [DATA_W-1:0] dadoR1;
    logic [DATA_W-1:0] dadoR2;
    logic [ADDR_W-1:0] addWr;
    logic [DATA_W-1:0] dadoWr;
    logic              wrEn;

    // status
    logic              done;
    logic              flag_z;
    logic              flag_c;

    // sequencer side
    modport master (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
        output instr_ready,
        output addR1, addR2, addWr, dadoWr, wrEn,
        input  dadoR1, dadoR2,
        output done, flag_z, flag_c
    );

    // decoder + register bank side
    modport slave (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
        input  instr_ready,
        input  addR1, addR2, addWr, dadoWr, wrEn,
        output dadoR1, dadoR2,
        input  done, flag_z, flag_c
    );
endinterface

// File: rtl/seq_acesso_regs.sv
// Register-to-register instruction sequencer for the Nano datapath.
// Takes one instruction at a time from the decoder, reads its operands from
// the 8x8 register bank (1-cycle registered read), runs them through a small
// ALU and writes the result back, then pulses done and updates the Z/C flags.
// Sequence: IDLE -> READ -> EXEC -> WB -> IDLE (LDI skips to WB, CMP skips WB).
module seq_acesso_regs #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    seq_acesso_regs_if.master bus,
    output logic [1:0]        state_dbg
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MOV = 3'd5;
    localparam logic [2:0] OP_LDI = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t state, state_nxt;

    // latched instruction fields (rs1/rs2 live directly in the address registers)
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] rd_q;

    // registered outputs and their next values
    logic [ADDR_W-1:0] addr1_q,  addr1_nxt;
    logic [ADDR_W-1:0] addr2_q,  addr2_nxt;
    logic [ADDR_W-1:0] addwr_q,  addwr_nxt;
    logic [DATA_W-1:0] dadowr_q, dadowr_nxt;
    logic              wren_q,   wren_nxt;
    logic              done_q,   done_nxt;
    logic              flag_z_q, flag_z_nxt;
    logic              flag_c_q, flag_c_nxt;

    // flags of the result sitting in WB, published on the done edge
    logic              res_z_q,  res_z_nxt;
    logic              res_c_q,  res_c_nxt;

    // ALU
    logic [DATA_W:0]   sum_w;
    logic [DATA_W-1:0] alu_r;
    logic              alu_c;
    logic              alu_z;

    logic              accept;

    assign accept    = (state == S_IDLE) && bus.instr_valid;
    assign state_dbg = state;

    // ready is purely a function of state, and never high while reset is held
    assign bus.instr_ready = (state == S_IDLE) && rst;

    assign bus.addR1  = addr1_q;
    assign bus.addR2  = addr2_q;
    assign bus.addWr  = addwr_q;
    assign bus.dadoWr = dadowr_q;
    assign bus.wrEn   = wren_q;
    assign bus.done   = done_q;
    assign bus.flag_z = flag_z_q;
    assign bus.flag_c = flag_c_q;

    // state register; reset drops any in-flight instruction on the spot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    state_nxt = (bus.instr_op == OP_LDI) ? S_WB : S_READ;
                end
            end
            S_READ:  state_nxt = S_EXEC;
            S_EXEC:  state_nxt = (op_q == OP_CMP) ? S_IDLE : S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ALU on the bank read data, valid during EXEC; everything wraps mod 2^DATA_W
    always_comb begin
        sum_w = {1'b0, bus.dadoR1} + {1'b0, bus.dadoR2};
        alu_r = '0;
        alu_c = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_r = sum_w[DATA_W-1:0];
                alu_c = sum_w[DATA_W];
            end
            OP_SUB, OP_CMP: begin
                alu_r = bus.dadoR1 - bus.dadoR2;
                alu_c = (bus.dadoR1 < bus.dadoR2);
            end
            OP_AND:  alu_r = bus.dadoR1 & bus.dadoR2;
            OP_OR:   alu_r = bus.dadoR1 | bus.dadoR2;
            OP_XOR:  alu_r = bus.dadoR1 ^ bus.dadoR2;
            OP_MOV:  alu_r = bus.dadoR1;
            default: alu_r = bus.dadoR1;
        endcase
        alu_z = (alu_r == '0);
    end

    // next values of the registered outputs, per state
    always_comb begin
        addr1_nxt  = addr1_q;
        addr2_nxt  = addr2_q;
        addwr_nxt  = addwr_q;
        dadowr_nxt = dadowr_q;
        wren_nxt   = 1'b0;
        done_nxt   = 1'b0;
        flag_z_nxt = flag_z_q;
        flag_c_nxt = flag_c_q;
        res_z_nxt  = res_z_q;
        res_c_nxt  = res_c_q;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (bus.instr_op == OP_LDI) begin
                        // immediate goes straight to write-back
                        wren_nxt   = 1'b1;
                        addwr_nxt  = bus.instr_rd;
                        dadowr_nxt = bus.instr_imm;
                        res_z_nxt  = (bus.instr_imm == '0);
                        res_c_nxt  = 1'b0;
                    end else begin
                        // present operand addresses; bank samples them next edge
                        addr1_nxt = bus.instr_rs1;
                        addr2_nxt = bus.instr_rs2;
                    end
                end
            end
            S_READ: begin
                // bank read in flight
            end
            S_EXEC: begin
                res_z_nxt = alu_z;
                res_c_nxt = alu_c;
                if (op_q == OP_CMP) begin
                    // compare only retires: flags, no write
                    done_nxt   = 1'b1;
                    flag_z_nxt = alu_z;
                    flag_c_nxt = alu_c;
                end else begin
                    wren_nxt   = 1'b1;
                    addwr_nxt  = rd_q;
                    dadowr_nxt = alu_r;
                end
            end
            S_WB: begin
                done_nxt   = 1'b1;
                flag_z_nxt = res_z_q;
                flag_c_nxt = res_c_q;
            end
            default: begin
            end
        endcase
    end

    // output and result registers; async reset also kills a pending wrEn
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr1_q  <= '0;
            addr2_q  <= '0;
            addwr_q  <= '0;
            dadowr_q <= '0;
            wren_q   <= 1'b0;
            done_q   <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            res_z_q  <= 1'b0;
            res_c_q  <= 1'b0;
        end else begin
            addr1_q  <= addr1_nxt;
            addr2_q  <= addr2_nxt;
            addwr_q  <= addwr_nxt;
            dadowr_q <= dadowr_nxt;
            wren_q   <= wren_nxt;
            done_q   <= done_nxt;
            flag_z_q <= flag_z_nxt;
            flag_c_q <= flag_c_nxt;
            res_z_q  <= res_z_nxt;
            res_c_q  <= res_c_nxt;
        end
    end

    // capture opcode and destination when an instruction is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q <= OP_ADD;
            rd_q <= '0;
        end else if (accept) begin
            op_q <= bus.instr_op;
            rd_q <= bus.instr_rd;
        end
    end

endmodule

// File: tb/tb_seq_acesso_regs.sv
// Bench for seq_acesso_regs: register-bank model (reset contents r[i]=i,
// registered reads) plus directed scenarios with hand-computed results.
module tb_seq_acesso_regs;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MOV = 3'd5;
    localparam logic [2:0] OP_LDI = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;
    logic       bank_clr;
    logic [7:0] bank [8];

    int checks = 0;
    int errors = 0;

    seq_acesso_regs_if bus ();

    seq_acesso_regs dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register bank model: registered reads, write on wrEn
    always_ff @(posedge clk) begin
        if (bank_clr) begin
            for (int i = 0; i < 8; i++) bank[i] <= 8'(i);
        end else if (bus.wrEn) begin
            bank[bus.addWr] <= bus.dadoWr;
        end
        bus.dadoR1 <= bank[bus.addR1];
        bus.dadoR2 <= bank[bus.addR2];
    end

    // restore r[i]=i while the sequencer is idle
    task automatic clear_bank();
        @(negedge clk);
        bank_clr = 1'b1;
        @(negedge clk);
        bank_clr = 1'b0;
    endtask

    // issue one instruction and watch it until done (bounded at 8 edges)
    task automatic run_instr(input logic [2:0] op, input logic [2:0] rd,
                             input logic [2:0] rs1, input logic [2:0] rs2,
                             input logic [7:0] imm,
                             output int done_k, output int wr_cnt,
                             output logic [2:0] wa, output logic [7:0] wd,
                             output logic [2:0] a1, output logic [2:0] a2,
                             output logic rdy);
        done_k = 0; wr_cnt = 0; wa = '0; wd = '0; a1 = '0; a2 = '0;
        @(negedge clk);
        rdy = bus.instr_ready;
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_rd    = rd;
        bus.instr_rs1   = rs1;
        bus.instr_rs2   = rs2;
        bus.instr_imm   = imm;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.instr_valid = 1'b0;
                a1 = bus.addR1;
                a2 = bus.addR2;
            end
            if (bus.wrEn) begin
                wr_cnt++;
                wa = bus.addWr;
                wd = bus.dadoWr;
            end
            if (bus.done) begin
                done_k = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bank_clr = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr_op = '0; bus.instr_rd = '0; bus.instr_rs1 = '0;
        bus.instr_rs2 = '0; bus.instr_imm = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.instr_ready); end
        checks++; if (bus.wrEn !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", bus.wrEn); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if ({bus.flag_z, bus.flag_c} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {bus.flag_z, bus.flag_c}); end
        checks++; if ({bus.addR1, bus.addR2, bus.addWr} !== 9'd0) begin errors++; $display("FAIL reset_addrs: got %h expected 0", {bus.addR1, bus.addR2, bus.addWr}); end
        checks++; if (bus.dadoWr !== 8'h00) begin errors++; $display("FAIL reset_dadowr: got %h expected 00", bus.dadoWr); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
        rst = 1'b1;
        bank_clr = 1'b0;
        @(negedge clk);
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", bus.instr_ready); end
    endtask

    task automatic test_add_sub();
        int dk, wc; logic [2:0] wa, a1, a2; logic [7:0] wd; logic rdy;
        clear_bank();
        run_instr(OP_ADD, 3'd1, 3'd2, 3'd3, 8'h00, dk, wc, wa, wd, a1, a2, rdy);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL add_ready: got %b expected 1", rdy); end
        checks++; if ({a1, a2} !== {3'd2, 3'd3}) begin errors++; $display("FAIL add_read_addr: got %0d,%0d expected 2,3", a1, a2); end
        checks++; if (wc !== 1) begin errors++; $display("FAIL add_wren_cycles: got %0d expected 1", wc); end
        checks++; if (wa !== 3'd1 || wd !== 8'h05) begin errors++; $display("FAIL add_write: got r%0d=%h expected r1=05", wa, wd); end
        checks++; if (dk !== 4) begin errors++; $display("FAIL add_latency: got %0d expected 4", dk); end
        checks++; if ({bus.flag_z, bus.flag_c} !== 2'b00) begin errors++; $display("FAIL add_flags: got %b expected 00", {bus.flag_z, bus.flag_c}); end
        checks++; if (bank[1] !== 8'h05) begin errors++; $display("FAIL add_bank: got %h expected 05", bank[1]); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b expected 0", bus.done); end

        run_instr(OP_SUB, 3'd0, 3'd2, 3'd3, 8'h00, dk, wc, wa, wd, a1, a2, rdy);
        checks++; if (wa !== 3'd0 || wd !== 8'hFF) begin errors++; $display("FAIL sub_write: got r%0d=%h expected r0=ff", wa, wd); end
        checks++; if ({bus.flag_z, bus.flag_c} !== 2'b01) begin errors++; $display("FAIL sub_flags: got zc=%b expected 01", {bus.flag_z, bus.flag_c}); end
        checks++; if (dk !== 4) begin errors++; $display("FAIL sub_latency: got %0d expected 4", dk); end
        checks++; if (bank[0] !== 8'hFF) begin errors++; $display("FAIL sub_bank: got %h expected ff", bank[0]); end
    endtask

    task automatic test_ldi_add();
        int dk, wc; logic [2:0] wa, a1, a2; logic [7:0] wd; logic rdy;
        clear_bank();
        run_instr(OP_LDI, 3'd4, 3'd0, 3'd0, 8'hFF, dk, wc, wa, wd, a1, a2, rdy);
        checks++; if (dk !== 2) begin errors++; $display("FAIL ldi_latency: got %0d expected 2", dk); end
        checks++; if (wc !== 1 || wa !== 3'd4 || wd !== 8'hFF) begin errors++; $display("FAIL ldi_write: got %0d x r%0d=%h expected 1 x r4=ff", wc, wa, wd); end
        checks++; if ({bus.flag_z, bus.flag_c} !== 2'b00) begin errors++; $display("FAIL ldi_flags: got %b expected 00", {bus.flag_z, bus.flag_c}); end
        run_instr(OP_ADD, 3'd5, 3'd4, 3'd1, 8'h00, dk, wc, wa, wd, a1, a2, rdy);
        checks++; if (bank[4] !== 8'hFF || bank[5] !== 8'h00) begin errors++; $display("FAIL ldi_add_bank: got r4=%h r5=%h expected ff 00", bank[4], bank[5]); end
        checks++; if ({bus.flag_z, bus.flag_c} !== 2'b11) begin errors++; $display("FAIL add_wrap_flags: got %b expected 11", {bus.flag_z, bus.flag_c}); end
        run_instr(OP_LDI, 3'd3, 3'd0, 3'd0, 8'h00, dk, wc, wa, wd, a1, a2, rdy);
        checks++; if ({bus.flag_z, bus.flag_c} !== 2'b10) begin errors++; $display("FAIL ldi_zero_flags: got %b expected 10", {bus.flag_z, bus.flag_c}); end
        checks++; if (bank[3] !== 8'h00) begin errors++; $display("FAIL ldi_zero_bank: got %h expected 00", bank[3]); end
    endtask

    task automatic test_cmp();
        int dk, wc; logic [2:0] wa, a1, a2; logic [7:0] wd; logic rdy;
        int dones;
        clear_bank();
        run_instr(OP_CMP, 3'd0, 3'd6, 3'd6, 8'h00, dk, wc, wa, wd, a1, a2, rdy);
        checks++; if (wc !== 0) begin errors++; $display("FAIL cmp_no_write: got %0d wrEn cycles expected 0", wc); end
        checks++; if (dk !== 3) begin errors++; $display("FAIL cmp_latency: got %0d expected 3", dk); end
        checks++; if ({bus.flag_z, bus.flag_c} !== 2'b10) begin errors++; $display("FAIL cmp_eq_flags: got %b expected 10", {bus.flag_z, bus.flag_c}); end
        checks++; if (bank[6] !== 8'h06 || bank[0] !== 8'h00) begin errors++; $display("FAIL cmp_bank: got r6=%h r0=%h expected 06 00", bank[6], bank[0]); end
        // flags hold while idle
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.done || bus.wrEn) dones++;
        end
        checks++; if (dones !== 0 || {bus.flag_z, bus.flag_c} !== 2'b10) begin errors++; $display("FAIL flags_hold: got act=%0d zc=%b expected 0 10", dones, {bus.flag_z, bus.flag_c}); end
        run_instr(OP_CMP, 3'd0, 3'd2, 3'd3, 8'h00, dk, wc, wa, wd, a1, a2, rdy);
        checks++; if ({bus.flag_z, bus.flag_c} !== 2'b01) begin errors++; $display("FAIL cmp_lt_flags: got %b expected 01", {bus.flag_z, bus.flag_c}); end
    endtask

    task automatic test_logic_ops();
        int dk, wc; logic [2:0] wa, a1, a2; logic [7:0] wd; logic rdy;
        // op, rd, rs1, rs2, expected result, z, c -- run in order on r[i]=i
        logic [2:0] t_op [9] = '{OP_AND, OP_OR, OP_XOR, OP_MOV, OP_ADD, OP_MOV, OP_SUB, OP_XOR, OP_SUB};
        logic [2:0] t_rd [9] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd2, 3'd4, 3'd6, 3'd7, 3'd5};
        logic [2:0] t_s1 [9] = '{3'd3, 3'd3, 3'd5, 3'd7, 3'd2, 3'd2, 3'd3, 3'd6, 3'd1};
        logic [2:0] t_s2 [9] = '{3'd5, 3'd4, 3'd6, 3'd0, 3'd2, 3'd0, 3'd1, 3'd6, 3'd4};
        logic [7:0] t_r  [9] = '{8'h01, 8'h07, 8'h03, 8'h07, 8'h0E, 8'h0E, 8'h02, 8'h00, 8'hF3};
        logic [1:0] t_zc [9] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01};
        clear_bank();
        for (int i = 0; i < 9; i++) begin
            run_instr(t_op[i], t_rd[i], t_s1[i], t_s2[i], 8'h00, dk, wc, wa, wd, a1, a2, rdy);
            checks++; if (wc !== 1 || wa !== t_rd[i] || wd !== t_r[i]) begin errors++; $display("FAIL alu_write[%0d]: got %0d x r%0d=%h expected 1 x r%0d=%h", i, wc, wa, wd, t_rd[i], t_r[i]); end
            checks++; if ({bus.flag_z, bus.flag_c} !== t_zc[i] || dk !== 4) begin errors++; $display("FAIL alu_flags[%0d]: got zc=%b lat=%0d expected %b 4", i, {bus.flag_z, bus.flag_c}, dk, t_zc[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int act;
        for (int pass = 0; pass < 2; pass++) begin
            clear_bank();
            @(negedge clk);
            bus.instr_valid = 1'b1;
            bus.instr_op = OP_ADD; bus.instr_rd = 3'd7; bus.instr_rs1 = 3'd1; bus.instr_rs2 = 3'd2;
            @(negedge clk);
            bus.instr_valid = 1'b0;
            @(negedge clk);
            // pass 0 stops in EXEC, pass 1 one cycle later in WB with wrEn high
            if (pass == 1) @(negedge clk);
            checks++; if (state_dbg !== 2'(2 + pass) || bus.wrEn !== 1'(pass)) begin errors++; $display("FAIL mid_pre_state[%0d]: got st=%0d wr=%b expected %0d %0d", pass, state_dbg, bus.wrEn, 2 + pass, pass); end
            #1 rst = 1'b0;
            #1;
            checks++; if (bus.wrEn !== 1'b0 || bus.instr_ready !== 1'b0 || state_dbg !== 2'd0) begin errors++; $display("FAIL mid_async[%0d]: got wr=%b rdy=%b st=%0d expected 0 0 0", pass, bus.wrEn, bus.instr_ready, state_dbg); end
            act = 0;
            repeat (2) begin
                @(negedge clk);
                if (bus.wrEn || bus.done) act++;
            end
            rst = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (bus.wrEn || bus.done) act++;
            end
            checks++; if (act !== 0) begin errors++; $display("FAIL mid_no_activity[%0d]: got %0d expected 0", pass, act); end
            checks++; if (bank[7] !== 8'h07) begin errors++; $display("FAIL mid_r7[%0d]: got %h expected 07", pass, bank[7]); end
            checks++; if (bus.instr_ready !== 1'b1 || {bus.flag_z, bus.flag_c} !== 2'b00) begin errors++; $display("FAIL mid_release[%0d]: got rdy=%b zc=%b expected 1 00", pass, bus.instr_ready, {bus.flag_z, bus.flag_c}); end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] b_rd [3] = '{3'd1, 3'd2, 3'd3};
        logic [2:0] b_s1 [3] = '{3'd1, 3'd1, 3'd2};
        logic [2:0] b_s2 [3] = '{3'd2, 3'd1, 3'd1};
        int acc_c [3];
        int n_acc = 0, dones = 0, wrs = 0, overlap = 0;
        logic prev_wr = 1'b0;
        logic acc_now;
        clear_bank();
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_op = OP_ADD; bus.instr_rd = b_rd[0]; bus.instr_rs1 = b_s1[0]; bus.instr_rs2 = b_s2[0];
        for (int c = 0; c < 40; c++) begin
            if (bus.done) dones++;
            if (bus.wrEn) begin
                wrs++;
                if (prev_wr) overlap++;
            end
            prev_wr = bus.wrEn;
            if (n_acc == 3 && dones == 3) break;
            acc_now = bus.instr_ready && bus.instr_valid;
            if (acc_now) begin
                acc_c[n_acc] = c;
                n_acc++;
            end
            @(negedge clk);
            if (acc_now) begin
                if (n_acc < 3) begin
                    bus.instr_rd = b_rd[n_acc]; bus.instr_rs1 = b_s1[n_acc]; bus.instr_rs2 = b_s2[n_acc];
                end else begin
                    bus.instr_valid = 1'b0;
                end
            end
        end
        bus.instr_valid = 1'b0;
        checks++; if (n_acc !== 3 || dones !== 3) begin errors++; $display("FAIL b2b_count: got acc=%0d done=%0d expected 3 3", n_acc, dones); end
        if (n_acc == 3) begin
            checks++; if (acc_c[1] - acc_c[0] !== 4 || acc_c[2] - acc_c[1] !== 4) begin errors++; $display("FAIL b2b_spacing: got %0d,%0d expected 4,4", acc_c[1] - acc_c[0], acc_c[2] - acc_c[1]); end
        end
        checks++; if (wrs !== 3 || overlap !== 0) begin errors++; $display("FAIL b2b_wren: got %0d cycles overlap=%0d expected 3 0", wrs, overlap); end
        checks++; if (bank[1] !== 8'h03 || bank[2] !== 8'h06 || bank[3] !== 8'h09) begin errors++; $display("FAIL b2b_bank: got %h %h %h expected 03 06 09", bank[1], bank[2], bank[3]); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_ldi_add();
        test_cmp();
        test_logic_ops();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
